// File: rtl/dpram_stream_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// dpram_stream_fifo_ctrl
//
// Turns an external true dual-port RAM into a first-word-fall-through stream
// FIFO. Port A carries the writes and port B the reads. Words read from port B
// come back one cycle after enb. They land in a 2-entry skid buffer that drives
// the downstream stream.
//
// Optional feature macro: FIFO_STATUS_EN (adds level / ovf_sticky / udf_sticky)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_data = word
//   out_valid/out_ready   downstream handshake, out_data = head word
//   wea/addra/data_i_a    RAM port A write controls
//   enb/addrb             RAM port B read controls
//   data_o_b              RAM port B registered read data (valid cycle after enb)
//   level                 (FIFO_STATUS_EN) total words held, registered
//   ovf_sticky            (FIFO_STATUS_EN) write attempted while not ready
//   udf_sticky            (FIFO_STATUS_EN) read attempted while empty
// ----------------------------------------------------------------------------
module dpram_stream_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] data_i_a,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] data_o_b
`ifdef FIFO_STATUS_EN
    ,
    output logic [ADDR_W+1:0] level,
    output logic              ovf_sticky,
    output logic              udf_sticky
`endif
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int LVL_W = ADDR_W + 2;
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  ram_cnt;
    logic              run;        // low in reset and for the first cycle after release
    logic              inflight;   // a RAM read returns on data_o_b this cycle
    logic [1:0]        skid_cnt;
    logic [DATA_W-1:0] skid0;      // oldest entry
    logic [DATA_W-1:0] skid1;
    logic [1:0]        held;
    logic              wr;
    logic              rd;
    logic              push;
    logic              pop;

    // ------------------------------------------------------------------------
    // Handshakes and RAM controls
    // ------------------------------------------------------------------------
    assign ram_cnt   = wptr - rptr;

    // in_ready is held low until one clock after reset so every output reads 0
    // while rst_n is low.
    assign in_ready  = run && (ram_cnt != DEPTH);
    assign wr        = in_valid && in_ready;

    assign out_valid = (skid_cnt != 2'd0);
    assign out_data  = skid0;
    assign pop       = out_valid && out_ready;
    assign push      = inflight;

    // Skid entries still occupied at the end of this cycle, counting the word
    // now returning from the RAM. Counting the pop of this cycle lets a read
    // issue every cycle under steady out_ready. The limit of two still keeps
    // the buffer from overflowing when out_ready drops.
    assign held      = skid_cnt + 2'(inflight) - 2'(pop);
    assign rd        = (ram_cnt != '0) && (held < 2'd2);

    assign wea       = wr;
    assign addra     = wptr[ADDR_W-1:0];
    assign data_i_a  = wr ? in_data : '0;
    assign enb       = rd;
    assign addrb     = rptr[ADDR_W-1:0];

    // ------------------------------------------------------------------------
    // Pointers and read pipeline
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            inflight <= 1'b0;
            run      <= 1'b0;
        end else begin
            run      <= 1'b1;
            inflight <= rd;
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Two-entry skid buffer; skid0 is always the head
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_cnt <= 2'd0;
            skid0    <= '0;
            skid1    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid0 <= data_o_b;
                    else                  skid1 <= data_o_b;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the returning word goes behind any survivor.
                    if (skid_cnt == 2'd1) begin
                        skid0 <= data_o_b;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= data_o_b;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_STATUS_EN
    // ------------------------------------------------------------------------
    // Status. level is loaded from next-state occupancy. It therefore shows
    // the words held in the same cycle as the pointers that produce it.
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0] ram_nxt;
    logic [1:0]       skid_nxt;
    logic [LVL_W-1:0] level_nxt;

    always_comb begin
        ram_nxt   = (wptr + PTR_W'(wr)) - (rptr + PTR_W'(rd));
        skid_nxt  = skid_cnt + 2'(push) - 2'(pop);
        level_nxt = LVL_W'(ram_nxt) + LVL_W'(rd) + LVL_W'(skid_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level      <= '0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            level <= level_nxt;
            if (in_valid && !in_ready)  ovf_sticky <= 1'b1;
            if (out_ready && !out_valid) udf_sticky <= 1'b1;
        end
    end
`endif

endmodule
